// File: rtl/button_conditioner.sv
// button_conditioner
// Per-key conditioner for active-low push buttons: two-flop synchroniser,
// debounce, clean level to the PIO, and a small per-key FSM that produces
// press/release strobes, a long-press level and auto-repeat strobes.
// Keys are fully independent; each one is an identical slice of the generate loop.
module button_conditioner #(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    input  logic [NUM_BUTTONS-1:0] raw_keys,
    output logic [NUM_BUTTONS-1:0] buttons_export,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic [NUM_BUTTONS-1:0] long_press,
    output logic [NUM_BUTTONS-1:0] repeat_pulse
);

    // Counter widths; a parameter of 1 still needs a 1-bit counter.
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
    localparam int REP_W  = (REPEAT_CYCLES > 1)   ? $clog2(REPEAT_CYCLES)   : 1;

    // Terminal counts; counters stop at these by explicit compare, never wrap.
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    // Per-key FSM encoding. The current state of key k is visible
    // hierarchically as g_key[k].state for checkers and waveform debug.
    typedef enum logic [1:0] {
        KEY_RELEASED = 2'd0,
        KEY_PRESSED  = 2'd1,
        KEY_HELD     = 2'd2
    } key_state_t;

    for (genvar k = 0; k < NUM_BUTTONS; k++) begin : g_key

        logic              sync1;
        logic              sync2;
        logic              stable;
        logic              stable_d;
        logic [DB_W-1:0]   db_cnt;

        key_state_t        state;
        key_state_t        state_nxt;
        logic [HOLD_W-1:0] hold_cnt;
        logic [HOLD_W-1:0] hold_cnt_nxt;
        logic [REP_W-1:0]  rep_cnt;
        logic [REP_W-1:0]  rep_cnt_nxt;

        logic              press_q;
        logic              release_q;
        logic              long_q;
        logic              repeat_q;
        logic              press_nxt;
        logic              release_nxt;
        logic              long_nxt;
        logic              repeat_nxt;

        // Edges of the debounced level (active-low: falling = press).
        logic              fell;
        logic              rose;

        assign fell = stable_d & ~stable;
        assign rose = ~stable_d & stable;

        // Bring the asynchronous pin into the clock domain; idle level is released (1).
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                sync1 <= 1'b1;
                sync2 <= 1'b1;
            end else begin
                sync1 <= raw_keys[k];
                sync2 <= sync1;
            end
        end

        // Accept a new level only after it has differed from stable for
        // DEBOUNCE_CYCLES consecutive cycles; any return clears the count.
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                db_cnt   <= '0;
                stable   <= 1'b1;
                stable_d <= 1'b1;
            end else begin
                stable_d <= stable;
                if (sync2 == stable) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    stable <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        // FSM state register together with its counters and registered outputs.
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                state     <= KEY_RELEASED;
                hold_cnt  <= '0;
                rep_cnt   <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                state     <= state_nxt;
                hold_cnt  <= hold_cnt_nxt;
                rep_cnt   <= rep_cnt_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
                long_q    <= long_nxt;
                repeat_q  <= repeat_nxt;
            end
        end

        // Next-state logic: release always wins over a coincident hold/repeat terminal.
        always_comb begin
            state_nxt = state;
            case (state)
                KEY_RELEASED: begin
                    if (fell) state_nxt = KEY_PRESSED;
                end
                KEY_PRESSED: begin
                    if (rose)                       state_nxt = KEY_RELEASED;
                    else if (hold_cnt == HOLD_LAST) state_nxt = KEY_HELD;
                end
                KEY_HELD: begin
                    if (rose) state_nxt = KEY_RELEASED;
                end
                default: state_nxt = KEY_RELEASED;
            endcase
        end

        // Output and counter next values, registered by the state register above.
        always_comb begin
            press_nxt    = 1'b0;
            release_nxt  = 1'b0;
            repeat_nxt   = 1'b0;
            long_nxt     = long_q;
            hold_cnt_nxt = hold_cnt;
            rep_cnt_nxt  = rep_cnt;
            case (state)
                KEY_RELEASED: begin
                    long_nxt = 1'b0;
                    if (fell) begin
                        press_nxt    = 1'b1;
                        hold_cnt_nxt = '0;
                    end
                end
                KEY_PRESSED: begin
                    if (rose) begin
                        release_nxt = 1'b1;
                    end else if (hold_cnt == HOLD_LAST) begin
                        long_nxt    = 1'b1;
                        repeat_nxt  = 1'b1;
                        rep_cnt_nxt = '0;
                    end else begin
                        hold_cnt_nxt = hold_cnt + 1'b1;
                    end
                end
                KEY_HELD: begin
                    if (rose) begin
                        long_nxt    = 1'b0;
                        release_nxt = 1'b1;
                    end else if (rep_cnt == REP_LAST) begin
                        repeat_nxt  = 1'b1;
                        rep_cnt_nxt = '0;
                    end else begin
                        rep_cnt_nxt = rep_cnt + 1'b1;
                    end
                end
                default: begin
                    long_nxt = 1'b0;
                end
            endcase
        end

        assign buttons_export[k] = stable;
        assign press_pulse[k]    = press_q;
        assign release_pulse[k]  = release_q;
        assign long_press[k]     = long_q;
        assign repeat_pulse[k]   = repeat_q;

    end : g_key

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
// Directed scenarios plus a randomized soak. A behavioural model derives the
// expected outputs from the raw-key history and event timing rules, and pushes
// one expected output vector per clock edge into a scoreboard queue.
module tb_button_conditioner;
  localparam int N = 4;
  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 3;
  localparam int W = 5 * N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] raw_keys = '1;
  logic [N-1:0] buttons_export;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] long_press;
  logic [N-1:0] repeat_pulse;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BUTTONS(N),
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .raw_keys(raw_keys),
    .buttons_export(buttons_export),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_press(long_press),
    .repeat_pulse(repeat_pulse)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // hist holds the last D+2 raw samples; hist[0..D-1] are the samples that
  // have already travelled through the two synchroniser stages.
  logic [N-1:0] hist[$];
  int cyc = 0;
  bit m_stable[N];
  bit m_fell[N];
  bit m_rose[N];
  bit m_down[N];
  int m_pe[N];

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back('1);
    for (int k = 0; k < N; k++) begin
      m_stable[k] = 1'b1;
      m_fell[k]   = 1'b0;
      m_rose[k]   = 1'b0;
      m_down[k]   = 1'b0;
      m_pe[k]     = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_edge();
    logic [N-1:0] e_btn, e_pr, e_rl, e_lg, e_rp;
    bit all_diff;
    hist.push_back(raw_keys);
    void'(hist.pop_front());
    for (int k = 0; k < N; k++) begin
      // strobes follow the level change by one edge
      e_pr[k] = m_fell[k];
      e_rl[k] = m_rose[k];
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) if (hist[j][k] == m_stable[k]) all_diff = 1'b0;
      m_fell[k] = 1'b0;
      m_rose[k] = 1'b0;
      if (all_diff) begin
        m_stable[k] = !m_stable[k];
        if (m_stable[k]) m_rose[k] = 1'b1;
        else m_fell[k] = 1'b1;
      end
      e_btn[k] = m_stable[k];
      if (e_pr[k]) begin
        m_down[k] = 1'b1;
        m_pe[k]   = cyc;
      end
      if (e_rl[k]) m_down[k] = 1'b0;
      e_lg[k] = m_down[k] && ((cyc - m_pe[k]) >= H);
      e_rp[k] = e_lg[k] && (((cyc - m_pe[k] - H) % R) == 0);
    end
    exp_q.push_back({e_btn, e_pr, e_rl, e_lg, e_rp});
    cyc++;
  endtask

  task automatic compare_out();
    logic [W-1:0] e;
    check_eq("scoreboard_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("buttons_export", buttons_export, e[4*N +: N]);
      check_eq("press_pulse",    press_pulse,    e[3*N +: N]);
      check_eq("release_pulse",  release_pulse,  e[2*N +: N]);
      check_eq("long_press",     long_press,     e[1*N +: N]);
      check_eq("repeat_pulse",   repeat_pulse,   e[0 +: N]);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_btn"},  buttons_export, 4'hF);
    check_eq({tag, "_pr"},   press_pulse,    4'h0);
    check_eq({tag, "_rl"},   release_pulse,  4'h0);
    check_eq({tag, "_long"}, long_press,     4'h0);
    check_eq({tag, "_rep"},  repeat_pulse,   4'h0);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive keys, let one rising edge happen, check at the next negedge.
  task automatic step(input logic [N-1:0] keys);
    raw_keys = keys;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_out();
  endtask

  // ---------------- stimulus ----------------
  int first_a, first_b, cnt_a, cnt_b;
  int pr_at, lg_at, rp1, rp2, rel_at, lg_fall;
  int hold_len, hi_len;
  logic [N-1:0] pr_vec;
  logic [N-1:0] lvl;
  int left[N];

  initial begin
    model_reset();
    rst_n = 1'b0;
    raw_keys = '1;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(4'hF);

    // clean press on key 0; step index i corresponds to edge i
    first_a = -1; first_b = -1; cnt_a = 0;
    for (int i = 0; i < 10; i++) begin
      step(4'hE);
      if (first_a < 0 && buttons_export[0] == 1'b0) first_a = i;
      if (press_pulse[0]) begin
        cnt_a++;
        if (first_b < 0) first_b = i;
      end
    end
    check_eq("clean_btn_edge", first_a, D + 1);
    check_eq("clean_press_edge", first_b, D + 2);
    check_eq("clean_press_count", cnt_a, 1);
    cnt_a = 0;
    for (int i = 0; i < D + 4; i++) begin
      step(4'hF);
      if (release_pulse[0]) cnt_a++;
    end
    check_eq("clean_release_count", cnt_a, 1);

    // bounce rejection on key 1
    cnt_a = 0; cnt_b = 0;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < D - 1; i++) begin
        step(4'hD);
        if ((press_pulse | release_pulse | repeat_pulse | long_press) != '0) cnt_a++;
        if (buttons_export != 4'hF) cnt_b++;
      end
      hi_len = $urandom_range(1, 3);
      for (int i = 0; i < hi_len; i++) begin
        step(4'hF);
        if ((press_pulse | release_pulse | repeat_pulse | long_press) != '0) cnt_a++;
        if (buttons_export != 4'hF) cnt_b++;
      end
    end
    for (int i = 0; i < D + 3; i++) begin
      step(4'hF);
      if ((press_pulse | release_pulse | repeat_pulse | long_press) != '0) cnt_a++;
      if (buttons_export != 4'hF) cnt_b++;
    end
    check_eq("bounce_strobes", cnt_a, 0);
    check_eq("bounce_btn_low", cnt_b, 0);

    // long press and repeat on key 2
    pr_at = -1; lg_at = -1; rp1 = -1; rp2 = -1;
    hold_len = $urandom_range(30, 45);
    for (int i = 0; i < hold_len; i++) begin
      step(4'hB);
      if (press_pulse[2]) pr_at = i;
      if (long_press[2] && lg_at < 0) lg_at = i;
      if (repeat_pulse[2]) begin
        if (rp1 < 0) rp1 = i;
        else if (rp2 < 0) rp2 = i;
      end
    end
    check_eq("long_delay", lg_at - pr_at, H);
    check_eq("first_repeat", rp1, lg_at);
    check_eq("repeat_spacing", rp2 - rp1, R);
    cnt_a = 0; rel_at = -1; lg_fall = -1;
    for (int i = 0; i < D + 4; i++) begin
      step(4'hF);
      if (release_pulse[2]) begin
        cnt_a++;
        rel_at = i;
      end
      if (!long_press[2] && lg_fall < 0) lg_fall = i;
    end
    check_eq("long_release_count", cnt_a, 1);
    check_eq("long_fall_with_release", lg_fall, rel_at);

    // simultaneous press on all keys
    first_a = -1; pr_vec = '0;
    for (int i = 0; i < 8; i++) begin
      step(4'h0);
      if (first_a < 0 && buttons_export == 4'h0) first_a = i;
      if (i == D + 2) pr_vec = press_pulse;
    end
    check_eq("simul_btn_edge", first_a, D + 1);
    check_eq("simul_press_vec", pr_vec, 4'hF);
    for (int i = 0; i < D + 4; i++) step(4'hF);

    // reset while key 3 is in the held state
    for (int i = 0; i < D + 2 + H + 4; i++) step(4'h7);
    check_eq("pre_reset_long", long_press[3], 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("in_reset");
    rst_n = 1'b1;
    first_a = -1; cnt_a = 0;
    for (int i = 0; i < 12; i++) begin
      step(4'h7);
      if (press_pulse[3] && first_a < 0) first_a = i;
      if (release_pulse != '0) cnt_a++;
    end
    check_eq("post_reset_press_edge", first_a, D + 2);
    check_eq("post_reset_no_release", cnt_a, 0);
    for (int i = 0; i < D + 4; i++) step(4'hF);

    // randomized soak: independent per-key levels with mixed durations
    lvl = '1;
    for (int k = 0; k < N; k++) left[k] = $urandom_range(1, 2 * D);
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if (left[k] == 0) begin
          lvl[k] = ~lvl[k];
          if ($urandom_range(0, 3) == 0) left[k] = $urandom_range(H, H + 4 * R);
          else left[k] = $urandom_range(1, 2 * D);
        end
        left[k]--;
      end
      step(lvl);
    end
    for (int i = 0; i < D + 4; i++) step(4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Per-key input conditioner between the DE1-SoC KEY pins and the `buttons_export` PIO input of the `nios` system. Synchronises the raw active-low push buttons, debounces them, and presents clean levels to the PIO. Also produces one-cycle press/release strobes, a long-press level and auto-repeat strobes for the game logic and the PIO edge-capture path. Keys are fully independent; there is no cross-key state.

## Interface

Parameters:
- `NUM_BUTTONS`, 4: number of keys conditioned.
- `DEBOUNCE_CYCLES`, 1000000: stable cycles needed to accept a level change (20 ms at 50 MHz); must be ≥ 2.
- `HOLD_CYCLES`, 25000000: cycles a press must persist to assert `long_press` (0.5 s).
- `REPEAT_CYCLES`, 10000000: auto-repeat period while long-pressed (0.2 s).

Ports:
- `clk_clk`  in  1  system clock. This is the single clock.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `raw_keys`  in  NUM_BUTTONS  asynchronous KEY pins, active-low (0 = pressed).
- `buttons_export`  out  NUM_BUTTONS  debounced level to the PIO, active-low.
- `press_pulse`  out  NUM_BUTTONS  one-cycle strobe on an accepted press.
- `release_pulse`  out  NUM_BUTTONS  one-cycle strobe on an accepted release.
- `long_press`  out  NUM_BUTTONS  high while the key has been held ≥ HOLD_CYCLES.
- `repeat_pulse`  out  NUM_BUTTONS  one-cycle strobe on each auto-repeat tick.

## Operation

- **Synchroniser.** Each key has 2 flops, `sync1` → `sync2`. Both reset to 1 (released).
- **Debounce counter.** One per key, width `$clog2(DEBOUNCE_CYCLES)`, reset 0.
  - If `sync2 == stable`: counter ← 0.
  - Else, if counter == DEBOUNCE_CYCLES−1: `stable` ← `sync2` and counter ← 0.
  - Else: counter +1.
  - Any return of `sync2` to `stable` before acceptance clears the counter, so a glitch shorter than DEBOUNCE_CYCLES is discarded.
- **Level output.** `buttons_export` = `stable` (registered). Reset value is all 1s.
- **Key FSM.** One per key, driven by `stable` and its previous-cycle copy `stable_d`.
  - RELEASED:
    - on a falling `stable`: assert `press_pulse`, clear the hold counter, go to PRESSED.
  - PRESSED:
    - on a rising `stable`: assert `release_pulse`, go to RELEASED.
    - else when hold counter == HOLD_CYCLES−1: set `long_press`, clear the repeat counter, assert `repeat_pulse`, go to HELD.
  - HELD:
    - on a rising `stable`: clear `long_press`, assert `release_pulse`, go to RELEASED.
    - else when repeat counter == REPEAT_CYCLES−1: assert `repeat_pulse` and clear the repeat counter.
- **Counter widths.** Hold and repeat counters are sized with `$clog2` of their parameter. They never wrap past terminal; terminal is an explicit compare.
- **Output registers.** All strobes and levels are registered. Reset values: `press_pulse`, `release_pulse` and `repeat_pulse` all 0; `long_press` 0; FSM in RELEASED.
- **Reset mid-operation.** All state returns to the reset values immediately (asynchronous reset). A key held through reset release is treated as a new press: `press_pulse` fires after the full debounce latency. No strobe fires during reset.

## Timing

- A raw change is first sampled into `sync1` at edge 0. If the raw level is held steady, `buttons_export` changes at edge DEBOUNCE_CYCLES+1.
- `press_pulse` / `release_pulse` are high for exactly one cycle, during the cycle after the `buttons_export` change (asserted at edge DEBOUNCE_CYCLES+2).
- `long_press` rises HOLD_CYCLES cycles after `press_pulse`. The first `repeat_pulse` coincides with that rise. Later `repeat_pulse`s are spaced exactly REPEAT_CYCLES apart.
- `long_press` falls in the same cycle that `release_pulse` is high.
- Simultaneous events on different keys are handled independently and in parallel, with identical latency.
- Minimum accepted press length is DEBOUNCE_CYCLES. Minimum press-to-release spacing is DEBOUNCE_CYCLES cycles of stable release.

## Test plan

Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.

- **Clean press.** `raw_keys[0]` 1→0 sampled at edge 0 → `buttons_export[0]` goes 0 at edge 5 and `press_pulse[0]` is high for one cycle from edge 6.
- **Bounce rejection.** `raw_keys[1]` low for 3 cycles, then high, repeated 5 times → `buttons_export` stays 4'hF and no strobes fire.
- **Long press and repeat.** Hold `raw_keys[2]` low → `long_press[2]` rises 10 cycles after `press_pulse[2]`, with `repeat_pulse` at that cycle and then every 3 cycles. On release → `long_press[2]` falls with a single `release_pulse[2]`.
- **Simultaneous keys.** `raw_keys` 4'hF→4'h0 at one edge → all four `press_pulse` bits are high in the same cycle and `buttons_export` = 4'h0 at edge 5.
- **Reset mid-press.** Assert `reset_reset_n` low with key 3 in HELD → all outputs go to reset values immediately. Release reset with the key still held → `press_pulse[3]` is seen after the full debounce latency, and there is no `release_pulse`.
